// File: rtl/multi_mode_game_counter_pkg.sv
// Shared types for the multi-mode game counter.
//   ctl_e : step selection carried on the control bus
//   who_e : which tally ended the game; also the game-state encoding
package game_counter_pkg;

    typedef enum logic [1:0] {
        CTL_INC1 = 2'b00,
        CTL_INC2 = 2'b01,
        CTL_DEC1 = 2'b10,
        CTL_DEC2 = 2'b11
    } ctl_e;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_e;

endpackage

// File: rtl/multi_mode_game_counter_if.sv
// Bus between a game controller (master) and the counter (slave).
//   master drives : init, load, en, control
//   slave drives  : count, winner, loser, count_winner, count_loser, gameover, who
interface multi_mode_game_counter_if #(
    parameter int WIDTH   = 4,
    parameter int TALLY_W = 4
);
    logic               init;
    logic [WIDTH-1:0]   load;
    logic               en;
    logic [1:0]         control;
    logic [WIDTH-1:0]   count;
    logic               winner;
    logic               loser;
    logic [TALLY_W-1:0] count_winner;
    logic [TALLY_W-1:0] count_loser;
    logic               gameover;
    logic [1:0]         who;

    modport master (
        output init, load, en, control,
        input  count, winner, loser, count_winner, count_loser, gameover, who
    );

    modport slave (
        input  init, load, en, control,
        output count, winner, loser, count_winner, count_loser, gameover, who
    );
endinterface

// File: rtl/multi_mode_game_counter_tally.sv
// Saturating event tally for one side of the game.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear tally (new game)
//   inc       : one event this cycle
//   tally     : events counted, saturates at WIN_LIMIT
//   hit_limit : this cycle's increment brings the tally to WIN_LIMIT
module game_tally #(
    parameter int TALLY_W   = 4,
    parameter int WIN_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [TALLY_W-1:0] tally,
    output logic               hit_limit
);
    localparam logic [TALLY_W-1:0] LIMIT      = TALLY_W'(WIN_LIMIT);
    localparam logic [TALLY_W-1:0] LIMIT_LESS = TALLY_W'(WIN_LIMIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tally <= '0;
        end else if (clr) begin
            tally <= '0;
        end else if (inc && (tally != LIMIT)) begin
            tally <= tally + 1'b1;
        end
    end

    // Lets the game-state register set on the same edge the tally lands on the limit.
    assign hit_limit = inc && !clr && (tally == LIMIT_LESS);

endmodule

// File: rtl/multi_mode_game_counter.sv
// Multi-mode game counter: WIDTH-bit up/down counter stepping +1/+STEP_BIG/-1/-STEP_BIG,
// with WINNER (hit all-ones) / LOSER (hit zero) pulses, saturating tallies and game-over.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of multi_mode_game_counter_if (init/load/en/control in,
//              count/winner/loser/count_winner/count_loser/gameover/who out)
//
// Game state (encoded as who_e so WHO comes straight off the register):
//   state      | meaning
//   WHO_NONE   | game in play, counter steps on en
//   WHO_WINNER | winner tally reached the limit, counter frozen
//   WHO_LOSER  | loser tally reached the limit, counter frozen
module multi_mode_game_counter
    import game_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int STEP_BIG  = 2,
    parameter int TALLY_W   = 4,
    parameter int WIN_LIMIT = 15,
    parameter bit WRAP      = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    multi_mode_game_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP_BIG);

    logic [WIDTH-1:0] count_q;
    logic             winner_q;
    logic             loser_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] next_count;
    logic             step_go;
    logic             win_ev;
    logic             los_ev;
    logic             win_hit;
    logic             los_hit;
    who_e             state;
    who_e             state_next;

    // Extra bit catches carry on increments and borrow on decrements alike.
    always_comb begin
        sum = {1'b0, count_q};
        case (ctl_e'(bus.control))
            CTL_INC1: sum = {1'b0, count_q} + ONE_W;
            CTL_INC2: sum = {1'b0, count_q} + STEP_W;
            CTL_DEC1: sum = {1'b0, count_q} - ONE_W;
            CTL_DEC2: sum = {1'b0, count_q} - STEP_W;
            default:  sum = {1'b0, count_q};
        endcase
        if (WRAP || !sum[WIDTH]) begin
            next_count = sum[WIDTH-1:0];
        end else if (bus.control[1]) begin
            next_count = '0;
        end else begin
            next_count = MAX;
        end
    end

    assign step_go = !bus.init && (state == WHO_NONE) && bus.en;
    // A clamped step that stays on MAX/0 is not an event.
    assign win_ev  = step_go && (next_count == MAX) && (next_count != count_q);
    assign los_ev  = step_go && (next_count == '0)  && (next_count != count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
        end else if (bus.init) begin
            count_q  <= bus.load;
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
        end else begin
            if (step_go) begin
                count_q <= next_count;
            end
            winner_q <= win_ev;
            loser_q  <= los_ev;
        end
    end

    game_tally #(
        .TALLY_W   (TALLY_W),
        .WIN_LIMIT (WIN_LIMIT)
    ) u_tally_winner (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.init),
        .inc       (win_ev),
        .tally     (bus.count_winner),
        .hit_limit (win_hit)
    );

    game_tally #(
        .TALLY_W   (TALLY_W),
        .WIN_LIMIT (WIN_LIMIT)
    ) u_tally_loser (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.init),
        .inc       (los_ev),
        .tally     (bus.count_loser),
        .hit_limit (los_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WHO_NONE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.init) begin
            state_next = WHO_NONE;
        end else if (state == WHO_NONE) begin
            if (win_hit) begin
                state_next = WHO_WINNER;
            end else if (los_hit) begin
                state_next = WHO_LOSER;
            end
        end
    end

    always_comb begin
        bus.gameover = (state != WHO_NONE);
        bus.who      = state;
    end

    assign bus.count  = count_q;
    assign bus.winner = winner_q;
    assign bus.loser  = loser_q;

endmodule

// File: tb/tb_multi_mode_game_counter.sv
module tb_multi_mode_game_counter;

    typedef struct {
        int count;
        int cw;
        int cl;
        int win;
        int los;
        int go;
        int who;
    } model_t;

    logic clk;
    logic rst;
    bit   armed;
    int   checks;
    int   errors;
    model_t m4;
    model_t m5;

    multi_mode_game_counter_if #(.WIDTH(4), .TALLY_W(4)) bus4 ();
    multi_mode_game_counter_if #(.WIDTH(5), .TALLY_W(4)) bus5 ();

    multi_mode_game_counter #(
        .WIDTH(4), .STEP_BIG(2), .TALLY_W(4), .WIN_LIMIT(15), .WRAP(1'b1)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    multi_mode_game_counter #(
        .WIDTH(5), .STEP_BIG(3), .TALLY_W(4), .WIN_LIMIT(15), .WRAP(1'b0)
    ) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game rules expressed directly on integers.
    function automatic model_t model_step(model_t m, bit r, bit init, int load, bit en, int ctl,
                                          int width, int step, int limit, bit wrap);
        model_t nx;
        int maxv;
        int delta;
        int n;
        nx = m;
        nx.win = 0;
        nx.los = 0;
        maxv = (1 << width) - 1;
        if (r || init) begin
            nx.count = r ? 0 : load;
            nx.cw = 0;
            nx.cl = 0;
            nx.go = 0;
            nx.who = 0;
            return nx;
        end
        if (m.go != 0 || !en) return nx;
        case (ctl)
            0: delta = 1;
            1: delta = step;
            2: delta = -1;
            default: delta = -step;
        endcase
        n = m.count + delta;
        if (wrap) n = (n + maxv + 1) % (maxv + 1);
        else if (n > maxv) n = maxv;
        else if (n < 0) n = 0;
        if (n != m.count && n == maxv) begin
            nx.win = 1;
            if (nx.cw < limit) nx.cw = nx.cw + 1;
            if (nx.cw == limit) begin nx.go = 1; nx.who = 2; end
        end
        if (n != m.count && n == 0) begin
            nx.los = 1;
            if (nx.cl < limit) nx.cl = nx.cl + 1;
            if (nx.cl == limit) begin nx.go = 1; nx.who = 1; end
        end
        nx.count = n;
        return nx;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m4 = model_step(m4, rst, bus4.init, int'(bus4.load), bus4.en, int'(bus4.control), 4, 2, 15, 1'b1);
        m5 = model_step(m5, rst, bus5.init, int'(bus5.load), bus5.en, int'(bus5.control), 5, 3, 15, 1'b0);
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m4_count",    int'(bus4.count),        m4.count);
            check("m4_winner",   int'(bus4.winner),       m4.win);
            check("m4_loser",    int'(bus4.loser),        m4.los);
            check("m4_cnt_win",  int'(bus4.count_winner), m4.cw);
            check("m4_cnt_lose", int'(bus4.count_loser),  m4.cl);
            check("m4_gameover", int'(bus4.gameover),     m4.go);
            check("m4_who",      int'(bus4.who),          m4.who);
            check("m5_count",    int'(bus5.count),        m5.count);
            check("m5_winner",   int'(bus5.winner),       m5.win);
            check("m5_loser",    int'(bus5.loser),        m5.los);
            check("m5_cnt_win",  int'(bus5.count_winner), m5.cw);
            check("m5_cnt_lose", int'(bus5.count_loser),  m5.cl);
            check("m5_gameover", int'(bus5.gameover),     m5.go);
            check("m5_who",      int'(bus5.who),          m5.who);
        end
    end

    task automatic tick4(input bit init, input int load, input bit en, input int ctl);
        bus4.init    = init;
        bus4.load    = 4'(load);
        bus4.en      = en;
        bus4.control = 2'(ctl);
        @(posedge clk);
        #1;
    endtask

    task automatic tick5(input bit init, input int load, input bit en, input int ctl);
        bus5.init    = init;
        bus5.load    = 5'(load);
        bus5.en      = en;
        bus5.control = 2'(ctl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        m4 = '{default: 0};
        m5 = '{default: 0};

        // Reset for two cycles with INIT held high: INIT must be ignored.
        rst = 1'b1;
        bus4.init = 1'b1; bus4.load = 4'd7; bus4.en = 1'b1; bus4.control = 2'd1;
        bus5.init = 1'b1; bus5.load = 5'd9; bus5.en = 1'b0; bus5.control = 2'd0;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        check("rst_count",    int'(bus4.count), 0);
        check("rst_loser",    int'(bus4.loser), 0);
        check("rst_winner",   int'(bus4.winner), 0);
        check("rst_tallies",  int'(bus4.count_winner) + int'(bus4.count_loser), 0);
        check("rst_gameover", int'(bus4.gameover), 0);
        check("rst_who",      int'(bus4.who), 0);
        check("rst_count5",   int'(bus5.count), 0);
        rst = 1'b0;
        bus5.init = 1'b0;

        // 13 +2 -> 15 winner, then +1 wraps to 0 loser.
        tick4(1, 13, 0, 0);
        check("init13", int'(bus4.count), 13);
        tick4(0, 0, 1, 1);
        check("w_count",  int'(bus4.count), 15);
        check("w_pulse",  int'(bus4.winner), 1);
        check("w_tally",  int'(bus4.count_winner), 1);
        tick4(0, 0, 1, 0);
        check("l_count",  int'(bus4.count), 0);
        check("l_pulse",  int'(bus4.loser), 1);
        check("w_drop",   int'(bus4.winner), 0);
        check("l_tally",  int'(bus4.count_loser), 1);

        // Passing over MAX / 0 is not an event.
        tick4(1, 14, 0, 0);
        tick4(0, 0, 1, 1);
        check("wrap14_count",  int'(bus4.count), 0);
        check("wrap14_loser",  int'(bus4.loser), 1);
        check("wrap14_winner", int'(bus4.winner), 0);
        tick4(1, 1, 0, 0);
        tick4(0, 0, 1, 3);
        check("wrap1_count",  int'(bus4.count), 15);
        check("wrap1_winner", int'(bus4.winner), 1);

        // Fifteen winner events end the game.
        tick4(1, 13, 0, 0);
        for (int i = 0; i < 15; i++) begin
            tick4(0, 0, 1, 1);
            if (i < 14) begin
                check("go_early", int'(bus4.gameover), 0);
                tick4(0, 0, 1, 3);
            end
        end
        check("go_tally", int'(bus4.count_winner), 15);
        check("go_set",   int'(bus4.gameover), 1);
        check("go_who",   int'(bus4.who), 2);
        for (int i = 0; i < 5; i++) begin
            tick4(0, 0, 1, 0);
            check("frz_count",  int'(bus4.count), 15);
            check("frz_winner", int'(bus4.winner), 0);
            check("frz_loser",  int'(bus4.loser), 0);
            check("frz_tally",  int'(bus4.count_winner), 15);
        end
        tick4(1, 3, 0, 0);
        check("new_count", int'(bus4.count), 3);
        check("new_tally", int'(bus4.count_winner), 0);
        check("new_go",    int'(bus4.gameover), 0);
        check("new_who",   int'(bus4.who), 0);

        // Fifteen loser events end the game on the loser side.
        tick4(1, 2, 0, 0);
        for (int i = 0; i < 15; i++) begin
            tick4(0, 0, 1, 3);
            if (i < 14) tick4(0, 0, 1, 1);
        end
        check("lgo_tally", int'(bus4.count_loser), 15);
        check("lgo_set",   int'(bus4.gameover), 1);
        check("lgo_who",   int'(bus4.who), 1);
        check("lgo_count", int'(bus4.count), 0);

        // EN low holds everything.
        tick4(1, 14, 0, 0);
        tick4(0, 0, 1, 0);
        check("en_pre", int'(bus4.count_winner), 1);
        for (int i = 0; i < 4; i++) begin
            tick4(0, 0, 0, 0);
            check("hold_count",  int'(bus4.count), 15);
            check("hold_winner", int'(bus4.winner), 0);
            check("hold_tally",  int'(bus4.count_winner), 1);
        end
        rst = 1'b1;
        tick4(1, 9, 1, 1);
        check("mid_rst_count", int'(bus4.count), 0);
        check("mid_rst_tally", int'(bus4.count_winner), 0);
        check("mid_rst_loser", int'(bus4.loser), 0);
        rst = 1'b0;
        bus4.init = 1'b0;
        bus4.en   = 1'b0;

        // Saturating 5-bit counter, STEP_BIG=3.
        tick5(1, 29, 0, 0);
        tick5(0, 0, 1, 1);
        check("s5_count",  int'(bus5.count), 31);
        check("s5_winner", int'(bus5.winner), 1);
        tick5(0, 0, 1, 0);
        check("s5_clamp",    int'(bus5.count), 31);
        check("s5_nowinner", int'(bus5.winner), 0);
        tick5(1, 30, 0, 0);
        tick5(0, 0, 1, 1);
        check("s5_top",     int'(bus5.count), 31);
        check("s5_top_win", int'(bus5.winner), 1);
        tick5(1, 2, 0, 0);
        tick5(0, 0, 1, 3);
        check("s5_zero",  int'(bus5.count), 0);
        check("s5_loser", int'(bus5.loser), 1);
        tick5(0, 0, 1, 2);
        check("s5_floor",   int'(bus5.count), 0);
        check("s5_noloser", int'(bus5.loser), 0);

        tick5(0, 0, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
